// File: rtl/onehot_codec_pkg.sv
// Shared mode encodings and width helpers for the binary/one-hot codec.
package onehot_codec_pkg;

  localparam logic MODE_BIN2OH = 1'b0;
  localparam logic MODE_OH2BIN = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    while ((result < 32'd32) && ((32'd1 << result) < value)) begin
      result = result + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/onehot_codec_if.sv
// Request/result handshake bundle of the codec; the source side is master, the codec is slave.
interface onehot_codec_if #(
  parameter int BIN_WIDTH    = 4,
  parameter int ONEHOT_WIDTH = 16
);
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic                    mode_i;
  logic [BIN_WIDTH-1:0]    bin_i;
  logic [ONEHOT_WIDTH-1:0] onehot_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [ONEHOT_WIDTH-1:0] onehot_o;
  logic [BIN_WIDTH-1:0]    bin_o;
  logic                    mode_o;
  logic                    err_o;

  modport master (
    output in_valid_i, mode_i, bin_i, onehot_i, out_ready_i,
    input  in_ready_o, out_valid_o, onehot_o, bin_o, mode_o, err_o
  );

  modport slave (
    input  in_valid_i, mode_i, bin_i, onehot_i, out_ready_i,
    output in_ready_o, out_valid_o, onehot_o, bin_o, mode_o, err_o
  );
endinterface

// File: rtl/onehot_codec_prienc.sv
// Lowest-set-bit priority encoder with zero and multi-hot flags; also used for grant encoding.
module onehot_to_bin_prienc #(
  parameter int ONEHOT_WIDTH = 16,
  parameter int BIN_WIDTH    = 4
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot_i,
  output logic [BIN_WIDTH-1:0]    idx_o,
  output logic                    zero_o,
  output logic                    multi_o
);

  localparam logic [ONEHOT_WIDTH-1:0] OH_ONE = {{(ONEHOT_WIDTH-1){1'b0}}, 1'b1};

  // Scan downward so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = {BIN_WIDTH{1'b0}};
    for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
      idx_o = onehot_i[i] ? BIN_WIDTH'(i) : idx_o;
    end
  end

  assign zero_o  = ~|onehot_i;
  assign multi_o = |(onehot_i & (onehot_i - OH_ONE));

endmodule

// File: rtl/onehot_codec.sv
// Registered bidirectional binary/one-hot converter with valid/ready on both sides and a saturating error count.
module onehot_codec
  import onehot_codec_pkg::*;
#(
  parameter int BIN_WIDTH    = 4,
  parameter int ONEHOT_WIDTH = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cnt_clr_i,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  onehot_codec_if.slave        bus
);

  localparam logic [ONEHOT_WIDTH-1:0] OH_ONE  = {{(ONEHOT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ONEHOT_WIDTH-1:0] OH_ZERO = {ONEHOT_WIDTH{1'b0}};
  localparam logic [BIN_WIDTH-1:0]    BIN_ZERO = {BIN_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic                    in_ready_s;
  logic                    accept_s;
  logic [ONEHOT_WIDTH-1:0] dec_oh_s;
  logic                    dec_err_s;
  logic [BIN_WIDTH-1:0]    pe_idx_s;
  logic                    pe_zero_s;
  logic                    pe_multi_s;
  logic                    res_err_s;

  logic                    out_valid_q, out_valid_d;
  logic [ONEHOT_WIDTH-1:0] onehot_q, onehot_d;
  logic [BIN_WIDTH-1:0]    bin_q, bin_d;
  logic                    mode_q, mode_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;

  onehot_to_bin_prienc #(
    .ONEHOT_WIDTH (ONEHOT_WIDTH),
    .BIN_WIDTH    (BIN_WIDTH)
  ) u_prienc (
    .onehot_i (bus.onehot_i),
    .idx_o    (pe_idx_s),
    .zero_o   (pe_zero_s),
    .multi_o  (pe_multi_s)
  );

  assign in_ready_s = !out_valid_q || bus.out_ready_i;
  assign accept_s   = bus.in_valid_i && in_ready_s;
  assign res_err_s  = (bus.mode_i == MODE_OH2BIN) ? (pe_zero_s | pe_multi_s) : dec_err_s;

  // Binary codes beyond the one-hot range decode to all-zero and are flagged.
  always_comb begin
    dec_oh_s  = OH_ZERO;
    dec_err_s = 1'b0;
    if (32'(bus.bin_i) < 32'(ONEHOT_WIDTH)) begin
      dec_oh_s = OH_ONE << bus.bin_i;
    end else begin
      dec_err_s = 1'b1;
    end
  end

  // Load on accept, drop valid on a drain without accept, otherwise hold everything.
  always_comb begin
    out_valid_d = out_valid_q;
    onehot_d    = onehot_q;
    bin_d       = bin_q;
    mode_d      = mode_q;
    err_d       = err_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      mode_d      = bus.mode_i;
      err_d       = res_err_s;
      case (bus.mode_i)
        MODE_BIN2OH: begin
          onehot_d = dec_oh_s;
          bin_d    = BIN_ZERO;
        end
        MODE_OH2BIN: begin
          onehot_d = OH_ZERO;
          bin_d    = pe_idx_s;
        end
        default: begin
          onehot_d = OH_ZERO;
          bin_d    = BIN_ZERO;
          err_d    = 1'b1;
        end
      endcase
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Clear wins over a same-cycle error increment.
  always_comb begin
    if (cnt_clr_i) begin
      err_cnt_d = {CNT_WIDTH{1'b0}};
    end else if (accept_s && res_err_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Result and counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      onehot_q    <= OH_ZERO;
      bin_q       <= BIN_ZERO;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      onehot_q    <= onehot_d;
      bin_q       <= bin_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = out_valid_q;
  assign bus.onehot_o    = onehot_q;
  assign bus.bin_o       = bin_q;
  assign bus.mode_o      = mode_q;
  assign bus.err_o       = err_q;
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: doc/onehot_codec.md
Name: onehot_codec

Overview:
- Parametrised, registered, bidirectional binary/one-hot converter with valid/ready handshake on both sides.
- Per-transaction mode selects the direction:
  - binary -> one-hot (the existing combinational encoder function, generalised);
  - one-hot -> binary, with illegal-code detection.
- Keeps a saturating error counter.
- Sits between a request source and a select/arbitration fabric, as a pipeline stage.

Parameters:
- BIN_WIDTH, 4, width of binary code; ONEHOT_WIDTH must be <= 2**BIN_WIDTH.
- ONEHOT_WIDTH, 16, width of one-hot code; may be non-power-of-two.
- CNT_WIDTH, 8, width of saturating error counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  input transaction valid.
- in_ready_o  out  1  block can accept input this cycle.
- mode_i  in  1  0 = BIN2OH, 1 = OH2BIN; sampled with the transaction.
- bin_i  in  BIN_WIDTH  binary input, used in BIN2OH.
- onehot_i  in  ONEHOT_WIDTH  one-hot input, used in OH2BIN.
- out_valid_o  out  1  output transaction valid.
- out_ready_i  in  1  downstream accepts output.
- onehot_o  out  ONEHOT_WIDTH  one-hot result; zero in OH2BIN.
- bin_o  out  BIN_WIDTH  binary result; zero in BIN2OH.
- mode_o  out  1  mode of the held result.
- err_o  out  1  held result came from an illegal input; qualified by out_valid_o.
- err_cnt_o  out  CNT_WIDTH  saturating count of accepted illegal transactions.
- cnt_clr_i  in  1  synchronous clear of err_cnt_o.

Behaviour:
- Reset (rst_ni low, asynchronous): out_valid_o=0, onehot_o=0, bin_o=0, mode_o=0, err_o=0, err_cnt_o=0. Release is synchronous to clk_i.
- Single output register stage. in_ready_o = !out_valid_o || out_ready_i (combinational).
- Accept = in_valid_i && in_ready_o. On accept, result registers load and out_valid_o=1 next cycle. Latency 1 cycle.
- Full throughput: accept on every cycle while out_ready_i=1.
- Output hold: out_valid_o && !out_ready_i -> all outputs hold stable; in_ready_o=0.
- Output drain: out_ready_i && out_valid_o with no accept -> out_valid_o=0 next cycle. Data registers keep their last value.
- Simultaneous drain and accept -> new result loads; out_valid_o stays 1.
- BIN2OH:
  - bin_i < ONEHOT_WIDTH: onehot_o = 1 << bin_i, err=0.
  - bin_i >= ONEHOT_WIDTH (only possible when ONEHOT_WIDTH < 2**BIN_WIDTH): onehot_o=0, err=1.
  - bin_o=0.
- OH2BIN:
  - Exactly one bit set: bin_o = its index, err=0.
  - Zero bits set: bin_o=0, err=1.
  - Multiple bits set: bin_o = index of the lowest set bit, err=1.
  - onehot_o=0.
- Error counter:
  - Increments by 1 on each accepted transaction whose computed err=1.
  - Saturates at 2**CNT_WIDTH-1.
  - cnt_clr_i has priority over increment: clear and error accept in the same cycle -> 0.
- in_valid_i while in_ready_o=0: ignored, no side effects. The source must hold its data until accepted; the block does not check this.
- Reset mid-transaction: the held result is discarded; out_valid_o=0 immediately (asynchronously).

Decomposition:
- Package onehot_codec_pkg:
  - mode constants MODE_BIN2OH=1'b0, MODE_OH2BIN=1'b1;
  - function clog2 for derived widths.
- One combinational sub-module onehot_to_bin_prienc (params ONEHOT_WIDTH, BIN_WIDTH).
  - Outputs: lowest-set index, zero flag, multi-hot flag.
  - Reused elsewhere for arbiter grant encoding.
- BIN2OH decode and the handshake/register logic stay inline.

Test Plan:
- Exhaustive BIN2OH sweep: bin_i=0..15 back-to-back, out_ready_i=1.
  - One result per cycle, latency 1.
  - bin_i=5 -> onehot_o=16'h0020, err_o=0.
  - bin_i=15 -> onehot_o=16'h8000.
- OH2BIN legal sweep: onehot_i=16'h0001..16'h8000 (walking one).
  - bin_o = 0..15, err_o=0.
  - err_cnt_o stays 0.
- OH2BIN illegal inputs:
  - onehot_i=16'h0000 -> bin_o=0, err_o=1.
  - onehot_i=16'h0a00 -> bin_o=9, err_o=1.
  - err_cnt_o=2 afterwards.
- Backpressure: out_ready_i=0 for 3 cycles with bin_i=3 accepted.
  - onehot_o=16'h0008 held stable; in_ready_o=0.
  - bin_i=7 presented meanwhile is not accepted.
  - Raise out_ready_i -> 7 accepted in the same cycle; onehot_o=16'h0080 next cycle.
- Params BIN_WIDTH=4, ONEHOT_WIDTH=10, CNT_WIDTH=2:
  - bin_i=12 -> onehot_o=0, err_o=1.
  - Five illegal accepts -> err_cnt_o saturates at 3.
  - cnt_clr_i together with an illegal accept -> err_cnt_o=0.
- Async reset: assert rst_ni low mid-cycle while out_valid_o=1.
  - out_valid_o, err_cnt_o, onehot_o go to 0 before the next clock edge.
  - First accept after release behaves normally.
